// File: rtl/stage_latch_pkg.sv
// Shared pipeline definitions for the stage latch: default widths, bubble
// word, channel indices and the occupancy encoding.
package stage_latch_pkg;

   localparam int          DEF_WIDTH    = 32;
   localparam int          DEF_NCH      = 3;
   localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

   // Channel positions inside one entry (channel k at bits [k*WIDTH +: WIDTH])
   localparam int CH_O  = 0;
   localparam int CH_D  = 1;
   localparam int CH_IR = 2;

   // Number of entries currently held by the 2-deep stage
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/stage_entry.sv
// One stage entry: a WIDTH*NCH register with load enable and an
// asynchronous active-low clear to the NOP bubble value.
module stage_entry
   import stage_latch_pkg::*;
#(
   parameter int                     WIDTH   = DEF_WIDTH,
   parameter int                     NCH     = DEF_NCH,
   parameter logic [WIDTH*NCH-1:0]   CLR_VAL = '0
) (
   input  logic                   clock,
   input  logic                   ctrl_reset,
   input  logic                   load,
   input  logic [WIDTH*NCH-1:0]   d,
   output logic [WIDTH*NCH-1:0]   q
);

   // Capture d when load is set; reset forces the bubble immediately
   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         q <= CLR_VAL;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/stage_latch.sv
// Two-entry in-order pipeline stage (head + skid) with a registered
// in_ready, dominant synchronous flush and NOP bubble on empty output.
module stage_latch
   import stage_latch_pkg::*;
#(
   parameter int                 WIDTH    = DEF_WIDTH,
   parameter int                 NCH      = DEF_NCH,
   parameter logic [WIDTH-1:0]   NOP_WORD = WIDTH'(DEF_NOP_WORD)
) (
   input  logic                   clock,
   input  logic                   ctrl_reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH*NCH-1:0]   in_data,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH*NCH-1:0]   out_data,
   output logic [1:0]             occupancy
);

   localparam int                 DW         = WIDTH * NCH;
   localparam logic [DW-1:0]      NOP_BUBBLE = {NCH{NOP_WORD}};

   occ_e            occ_q;
   occ_e            occ_d;
   logic            in_ready_q;
   logic            in_ready_d;
   logic            accept;
   logic            consume;
   logic            head_ld;
   logic            skid_ld;
   logic            head_from_skid;
   logic [DW-1:0]   head_d;
   logic [DW-1:0]   head_q;
   logic [DW-1:0]   skid_q;

   // A flush cycle performs no transfer in either direction
   assign accept  = in_valid && in_ready_q && !flush;
   assign consume = out_valid && out_ready && !flush;

   // Next occupancy and register load enables
   always_comb begin
      occ_d          = occ_q;
      head_ld        = 1'b0;
      skid_ld        = 1'b0;
      head_from_skid = 1'b0;
      if (flush) begin
         occ_d = OCC_EMPTY;
      end else begin
         case (occ_q)
            OCC_EMPTY: begin
               if (accept) begin
                  head_ld = 1'b1;
                  occ_d   = OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (accept && consume) begin
                  head_ld = 1'b1;
               end else if (accept) begin
                  skid_ld = 1'b1;
                  occ_d   = OCC_FULL;
               end else if (consume) begin
                  occ_d = OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               // in_ready is low here, so only the skid-to-head move happens
               if (consume) begin
                  head_ld        = 1'b1;
                  head_from_skid = 1'b1;
                  occ_d          = OCC_ONE;
               end
            end
            default: occ_d = OCC_EMPTY;
         endcase
      end
   end

   assign in_ready_d = (occ_d != OCC_FULL);
   assign head_d     = head_from_skid ? skid_q : in_data;

   // Control state; reset leaves in_ready low until the first edge after release
   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         occ_q      <= OCC_EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         occ_q      <= occ_d;
         in_ready_q <= in_ready_d;
      end
   end

   stage_entry #(
      .WIDTH   (WIDTH),
      .NCH     (NCH),
      .CLR_VAL (NOP_BUBBLE)
   ) u_head (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .load       (head_ld),
      .d          (head_d),
      .q          (head_q)
   );

   stage_entry #(
      .WIDTH   (WIDTH),
      .NCH     (NCH),
      .CLR_VAL (NOP_BUBBLE)
   ) u_skid (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .load       (skid_ld),
      .d          (in_data),
      .q          (skid_q)
   );

   // Stale head contents are hidden behind the bubble whenever the stage is empty
   assign out_valid = (occ_q != OCC_EMPTY);
   assign out_data  = out_valid ? head_q : NOP_BUBBLE;
   assign in_ready  = in_ready_q;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_stage_latch.sv
// Bench for stage_latch: directed vector table plus hand-written reset,
// mid-transfer reset and parameter sequences.
module tb_stage_latch;

   logic          clock;
   logic          ctrl_reset;
   logic          in_valid;
   logic          in_ready;
   logic [95:0]   in_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [95:0]   out_data;
   logic [1:0]    occupancy;

   logic          p_in_valid;
   logic          p_in_ready;
   logic [31:0]   p_in_data;
   logic          p_flush;
   logic          p_out_valid;
   logic          p_out_ready;
   logic [31:0]   p_out_data;
   logic [1:0]    p_occupancy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic          iv;
      logic [95:0]   din;
      logic          ordy;
      logic          fl;
      logic          e_ov;
      logic [95:0]   e_data;
      logic [1:0]    e_occ;
      logic          e_ir;
   } vec_t;

   vec_t vecs[16];

   stage_latch u_dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .occupancy  (occupancy)
   );

   stage_latch #(.WIDTH(8), .NCH(4)) u_p (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .in_valid   (p_in_valid),
      .in_ready   (p_in_ready),
      .in_data    (p_in_data),
      .flush      (p_flush),
      .out_valid  (p_out_valid),
      .out_ready  (p_out_ready),
      .out_data   (p_out_data),
      .occupancy  (p_occupancy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Entry with channel 0 = x and distinct values on the other channels
   function automatic logic [95:0] mk(input logic [31:0] x);
      return {x + 32'h0000_0200, x + 32'h0000_0100, x};
   endfunction

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_main(input string tag, input logic ov, input logic [95:0] data,
                             input logic [1:0] occ, input logic ir);
      check({tag, " out_valid"}, 96'(out_valid), 96'(ov));
      check({tag, " out_data"},  out_data, data);
      check({tag, " occupancy"}, 96'(occupancy), 96'(occ));
      check({tag, " in_ready"},  96'(in_ready), 96'(ir));
   endtask

   initial begin
      // Stream A,B,C then drain
      vecs[0]  = '{1'b1, mk(32'h11), 1'b1, 1'b0, 1'b1, mk(32'h11), 2'd1, 1'b1};
      vecs[1]  = '{1'b1, mk(32'h22), 1'b1, 1'b0, 1'b1, mk(32'h22), 2'd1, 1'b1};
      vecs[2]  = '{1'b1, mk(32'h33), 1'b1, 1'b0, 1'b1, mk(32'h33), 2'd1, 1'b1};
      vecs[3]  = '{1'b0, mk(32'h00), 1'b1, 1'b0, 1'b0, 96'h0,      2'd0, 1'b1};
      // Backpressure: fill, offer an extra word while full, then drain
      vecs[4]  = '{1'b1, mk(32'hAA), 1'b0, 1'b0, 1'b1, mk(32'hAA), 2'd1, 1'b1};
      vecs[5]  = '{1'b1, mk(32'hBB), 1'b0, 1'b0, 1'b1, mk(32'hAA), 2'd2, 1'b0};
      vecs[6]  = '{1'b1, mk(32'hEE), 1'b0, 1'b0, 1'b1, mk(32'hAA), 2'd2, 1'b0};
      vecs[7]  = '{1'b0, mk(32'h00), 1'b1, 1'b0, 1'b1, mk(32'hBB), 2'd1, 1'b1};
      vecs[8]  = '{1'b0, mk(32'h00), 1'b1, 1'b0, 1'b0, 96'h0,      2'd0, 1'b1};
      // Flush while full with a word offered and consume requested
      vecs[9]  = '{1'b1, mk(32'h66), 1'b0, 1'b0, 1'b1, mk(32'h66), 2'd1, 1'b1};
      vecs[10] = '{1'b1, mk(32'h77), 1'b0, 1'b0, 1'b1, mk(32'h66), 2'd2, 1'b0};
      vecs[11] = '{1'b1, mk(32'hCC), 1'b1, 1'b1, 1'b0, 96'h0,      2'd0, 1'b1};
      vecs[12] = '{1'b0, mk(32'h00), 1'b1, 1'b0, 1'b0, 96'h0,      2'd0, 1'b1};
      // Flush with in_ready high: the offered word must still be dropped
      vecs[13] = '{1'b1, mk(32'h88), 1'b0, 1'b0, 1'b1, mk(32'h88), 2'd1, 1'b1};
      vecs[14] = '{1'b1, mk(32'h99), 1'b1, 1'b1, 1'b0, 96'h0,      2'd0, 1'b1};
      vecs[15] = '{1'b0, mk(32'h00), 1'b1, 1'b0, 1'b0, 96'h0,      2'd0, 1'b1};

      // Reset held with live-looking inputs
      ctrl_reset  = 1'b0;
      in_valid    = 1'b1;
      in_data     = mk(32'h99);
      out_ready   = 1'b1;
      flush       = 1'b0;
      p_in_valid  = 1'b0;
      p_in_data   = 32'h0;
      p_flush     = 1'b0;
      p_out_ready = 1'b0;
      #2;
      check_main("reset_async", 1'b0, 96'h0, 2'd0, 1'b0);
      repeat (2) tick();
      check_main("reset_held", 1'b0, 96'h0, 2'd0, 1'b0);
      check("p_reset out_data", 96'(p_out_data), 96'h0);
      #3 ctrl_reset = 1'b1;
      #1;
      check_main("release_pre_edge", 1'b0, 96'h0, 2'd0, 1'b0);
      tick();
      check_main("first_edge", 1'b0, 96'h0, 2'd0, 1'b1);
      in_valid = 1'b0;

      for (int i = 0; i < 16; i++) begin
         in_valid  = vecs[i].iv;
         in_data   = vecs[i].din;
         out_ready = vecs[i].ordy;
         flush     = vecs[i].fl;
         tick();
         check_main($sformatf("row%0d", i), vecs[i].e_ov, vecs[i].e_data,
                    vecs[i].e_occ, vecs[i].e_ir);
      end

      // Reset mid-transfer with two entries held
      in_valid  = 1'b1;
      in_data   = mk(32'h41);
      out_ready = 1'b0;
      flush     = 1'b0;
      tick();
      in_data = mk(32'h42);
      tick();
      check_main("mid_full", 1'b1, mk(32'h41), 2'd2, 1'b0);
      #3 ctrl_reset = 1'b0;
      #1;
      check_main("mid_async_clear", 1'b0, 96'h0, 2'd0, 1'b0);
      tick();
      #3 ctrl_reset = 1'b1;
      in_valid = 1'b0;
      tick();
      check_main("mid_release", 1'b0, 96'h0, 2'd0, 1'b1);
      in_valid = 1'b1;
      in_data  = mk(32'h55);
      tick();
      check_main("mid_push55", 1'b1, mk(32'h55), 2'd1, 1'b1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check_main("mid_drain", 1'b0, 96'h0, 2'd0, 1'b1);

      // Narrow, wide-entry instance: byte lanes pass through unchanged
      p_in_valid = 1'b1;
      p_in_data  = 32'hDDCC_BBAA;
      tick();
      p_in_valid = 1'b0;
      check("p_push out_valid", 96'(p_out_valid), 96'h1);
      check("p_push out_data",  96'(p_out_data),  96'hDDCC_BBAA);
      check("p_push occupancy", 96'(p_occupancy), 96'h1);
      p_out_ready = 1'b1;
      tick();
      check("p_drain out_valid", 96'(p_out_valid), 96'h0);
      check("p_drain out_data",  96'(p_out_data),  96'h0);
      check("p_drain in_ready",  96'(p_in_ready),  96'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
